// File: rtl/galois_mult_interleaved_if.sv
// galois_mult_interleaved_if: en/done handshake and operand bus for galois_mult_interleaved
//   en, mode, modulus, num1, num2, num3 : requester -> multiplier
//   product, busy, done                  : multiplier -> requester
interface galois_mult_interleaved_if #(parameter int N_BITS = 254);
   logic              en;
   logic [1:0]        mode;
   logic [N_BITS-1:0] modulus;
   logic [N_BITS-1:0] num1;
   logic [N_BITS-1:0] num2;
   logic [N_BITS-1:0] num3;
   logic [N_BITS-1:0] product;
   logic              busy;
   logic              done;
   modport master (output en, mode, modulus, num1, num2, num3, input product, busy, done);
   modport slave (input en, mode, modulus, num1, num2, num3, output product, busy, done);
endinterface

// File: rtl/galois_mult_interleaved.sv
// galois_mult_interleaved: iterative interleaved (Blakley) modular multiplier, MUL / SQR / MAC
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : slave side of galois_mult_interleaved_if (en, mode, modulus, num1..num3 in; product, busy, done out)
//   GALOIS_MULT_OPERAND_REDUCE_EN : adds a PRE cycle that folds operands in [0, 2p-1] into [0, p-1]
module galois_mult_interleaved #(
   parameter int N_BITS = 254,
   parameter int STEPS  = 1
) (
   input logic                    clk,
   input logic                    rst,
   galois_mult_interleaved_if.slave bus
);
   localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   typedef enum logic [2:0] {IDLE, PRE, RUN, ACC, DONE} state_t;
   state_t            state, state_n;
   logic [N_BITS-1:0] p_r, a_r, b_r, c_r, acc, acc_run, acc_add, product_r;
   logic [CW-1:0]     cnt;
   logic              mac, accept, last;

   // one conditional subtraction; x < 2p keeps the result below p
   function automatic logic [N_BITS-1:0] red(input logic [N_BITS:0] x, input logic [N_BITS-1:0] p);
      return (x >= {1'b0, p}) ? N_BITS'(x - {1'b0, p}) : x[N_BITS-1:0];
   endfunction

   // b is shifted left each cycle, so the bit for step i is always at N_BITS-1-i
   always_comb begin
      acc_run = acc;
      for (int i = 0; i < STEPS; i++) begin
         acc_run = red({acc_run, 1'b0}, p_r);
         acc_run = red({1'b0, acc_run} + (b_r[N_BITS-1-i] ? {1'b0, a_r} : '0), p_r);
      end
   end

   assign acc_add = red({1'b0, acc} + {1'b0, c_r}, p_r);
   assign accept  = bus.en && (state == IDLE || state == DONE);
   assign last    = cnt == CW'(STEPS - 1);

   always_ff @(posedge clk)
      state <= !rst ? IDLE : state_n;

   always_comb begin
      state_n = state;
      unique case (state)
`ifdef GALOIS_MULT_OPERAND_REDUCE_EN
         IDLE, DONE: state_n = accept ? PRE : state;
`else
         IDLE, DONE: state_n = accept ? RUN : state;
`endif
         PRE:        state_n = RUN;
         RUN:        state_n = last ? (mac ? ACC : DONE) : RUN;
         ACC:        state_n = DONE;
         default:    state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = !(state == IDLE || state == DONE);
      bus.done = state == DONE;
   end

   assign bus.product = product_r;

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc       <= '0;
         cnt       <= '0;
         product_r <= '0;
      end else begin
         if (accept) begin
            mac <= bus.mode == 2'b10;
            p_r <= bus.modulus;
            a_r <= bus.num1;
            b_r <= bus.mode == 2'b01 ? bus.num1 : bus.num2;
            c_r <= bus.num3;
            acc <= '0;
            cnt <= CW'(N_BITS - 1);
`ifdef GALOIS_MULT_OPERAND_REDUCE_EN
         end else if (state == PRE) begin
            a_r <= red({1'b0, a_r}, p_r);
            b_r <= red({1'b0, b_r}, p_r);
            c_r <= red({1'b0, c_r}, p_r);
`endif
         end else if (state == RUN) begin
            acc <= acc_run;
            b_r <= b_r << STEPS;
            cnt <= last ? cnt : cnt - CW'(STEPS);
         end else if (state == ACC) begin
            acc <= acc_add;
         end
         if (state_n == DONE && state != DONE)
            product_r <= state == ACC ? acc_add : acc_run;
      end
   end
endmodule
